// File: rtl/mtr_drv.sv
// rtl/mtr_drv.sv - dead-time protected dual H-bridge PWM driver with over-current shutdown
module mtr_drv #(
    parameter int DEAD      = 32,
    parameter int BLANK     = 128,
    parameter int OVR_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               pwr_up,
    input  logic               OVR_I_lft,
    input  logic               OVR_I_rght,
    output logic               lft_PWM1,
    output logic               lft_PWM2,
    output logic               rght_PWM1,
    output logic               rght_PWM2,
    output logic               PWM_synch,
    output logic               OVR_I_shtdwn
);

    localparam logic [5:0]  DEAD_V  = 6'(DEAD);
    localparam logic [10:0] BLANK_V = 11'(BLANK);
    localparam logic [3:0]  LIMIT_V = 4'(OVR_LIMIT);

    logic [10:0]        cnt;
    logic [10:0]        duty_lft, duty_rght;
    logic signed [11:0] lft_half, rght_half;
    logic               raw_lft, raw_rght, raw_lft_d, raw_rght_d;
    logic [5:0]         dt_lft, dt_rght, dt_lft_nxt, dt_rght_nxt;
    logic               ovr_seen, ovr_evt, gate_en, last_cyc;
    logic [3:0]         ovr_cnt;

    assign lft_half  = lft_spd >>> 1;
    assign rght_half = rght_spd >>> 1;
    assign last_cyc  = (cnt == 11'h7FF);
    assign ovr_evt   = (OVR_I_lft | OVR_I_rght) && (cnt >= BLANK_V) && pwr_up;
    assign gate_en   = pwr_up & ~OVR_I_shtdwn;

    // Gates are qualified with the updated dt so an edge of raw can never reuse a stale saturated count.
    always_comb begin
        dt_lft_nxt  = dt_lft;
        dt_rght_nxt = dt_rght;
        if (raw_lft != raw_lft_d)
            dt_lft_nxt = 6'd0;
        else if (dt_lft < DEAD_V)
            dt_lft_nxt = dt_lft + 6'd1;
        if (raw_rght != raw_rght_d)
            dt_rght_nxt = 6'd0;
        else if (dt_rght < DEAD_V)
            dt_rght_nxt = dt_rght + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 11'd0;
            PWM_synch    <= 1'b0;
            duty_lft     <= 11'h400;
            duty_rght    <= 11'h400;
            raw_lft      <= 1'b0;
            raw_rght     <= 1'b0;
            raw_lft_d    <= 1'b0;
            raw_rght_d   <= 1'b0;
            dt_lft       <= 6'd0;
            dt_rght      <= 6'd0;
            lft_PWM1     <= 1'b0;
            lft_PWM2     <= 1'b0;
            rght_PWM1    <= 1'b0;
            rght_PWM2    <= 1'b0;
            ovr_seen     <= 1'b0;
            ovr_cnt      <= 4'd0;
            OVR_I_shtdwn <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            PWM_synch <= (cnt == 11'h7FE);

            if (last_cyc) begin
                duty_lft  <= 11'h400 + lft_half[10:0];
                duty_rght <= 11'h400 + rght_half[10:0];
            end

            raw_lft    <= (cnt < duty_lft);
            raw_rght   <= (cnt < duty_rght);
            raw_lft_d  <= raw_lft;
            raw_rght_d <= raw_rght;
            dt_lft     <= dt_lft_nxt;
            dt_rght    <= dt_rght_nxt;

            lft_PWM1  <= gate_en &  raw_lft  & (dt_lft_nxt  >= DEAD_V);
            lft_PWM2  <= gate_en & ~raw_lft  & (dt_lft_nxt  >= DEAD_V);
            rght_PWM1 <= gate_en &  raw_rght & (dt_rght_nxt >= DEAD_V);
            rght_PWM2 <= gate_en & ~raw_rght & (dt_rght_nxt >= DEAD_V);

            // An event in the closing cycle still belongs to the period being closed.
            if (last_cyc) begin
                ovr_seen <= 1'b0;
                if (ovr_seen | ovr_evt) begin
                    if (ovr_cnt != 4'hF)
                        ovr_cnt <= ovr_cnt + 4'd1;
                end else begin
                    ovr_cnt <= 4'd0;
                end
            end else if (ovr_evt) begin
                ovr_seen <= 1'b1;
            end

            if (ovr_cnt >= LIMIT_V)
                OVR_I_shtdwn <= 1'b1;
        end
    end

endmodule
